// File: rtl/banked_memory_ctrl_if.sv
// Request/response bus of the banked memory controller.
// The master issues requests and consumes responses; the slave is the controller.
interface banked_memory_ctrl_if #(
    parameter int LANE_WIDTH = 8,
    parameter int LANES      = 4,
    parameter int ADDR_WIDTH = 16
);
    localparam int W = LANES * LANE_WIDTH;

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_wren;
    logic [LANES-1:0]      req_be;
    logic [ADDR_WIDTH-1:0] req_address;
    logic [W-1:0]          req_data;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [W-1:0]          rsp_data;
    logic                  rsp_error;
    logic                  rsp_wren;

    modport master (
        output req_valid, req_wren, req_be, req_address, req_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_error, rsp_wren
    );

    modport slave (
        input  req_valid, req_wren, req_be, req_address, req_data, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_error, rsp_wren
    );
endinterface

// File: rtl/banked_memory_ctrl.sv
// Banked byte-lane data memory with a valid/ready request port, a two-stage
// read pipeline, per-access range checking and a credit-limited response FIFO.
// Narrow banks only own lane-0 storage and replicate that byte on reads.
module banked_memory_ctrl #(
    parameter int                   LANE_WIDTH      = 8,
    parameter int                   LANES           = 4,
    parameter int                   ADDR_WIDTH      = 16,
    parameter int                   BANK_ADDR_WIDTH = 12,
    parameter int                   NUM_BANKS       = 3,
    parameter int                   BANK_DEPTH      = 3072,
    parameter logic [NUM_BANKS-1:0] NARROW_MASK     = 3'b010,
    parameter int                   FIFO_DEPTH      = 4
) (
    input  logic                clock,
    input  logic                reset_n,
    banked_memory_ctrl_if.slave bus
);
    localparam int W      = LANES * LANE_WIDTH;
    localparam int BANK_W = ADDR_WIDTH - BANK_ADDR_WIDTH;
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);

    // FIFO pointers wrap modulo FIFO_DEPTH, which need not be a power of two
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? {PTR_W{1'b0}} : p + PTR_W'(1'b1);
    endfunction

    // request decode
    logic [BANK_W-1:0]               bank_s;
    logic [BANK_ADDR_WIDTH-1:0]      offset_s;
    logic                            in_range_s;
    logic                            narrow_s;
    logic                            accept_s;
    logic [NUM_BANKS-1:0][LANES-1:0] bank_we_s;
    logic [NUM_BANKS-1:0]            bank_re_s;
    logic [LANE_WIDTH-1:0]           bank_rd_s [NUM_BANKS][LANES];
    logic [LANE_WIDTH-1:0]           lane_rd_s [LANES];
    logic [W-1:0]                    rd_word_s;

    // pipeline stage 1 and 2
    logic              s1_valid_d, s1_valid_q, s1_wren_d, s1_wren_q;
    logic              s1_err_d, s1_err_q, s1_narrow_d, s1_narrow_q;
    logic [BANK_W-1:0] s1_bank_d, s1_bank_q;
    logic              s2_valid_d, s2_valid_q, s2_wren_d, s2_wren_q, s2_err_d, s2_err_q;
    logic [W-1:0]      s2_data_d, s2_data_q;

    // response FIFO and credit counter
    logic [W-1:0]      fifo_data_q [FIFO_DEPTH];
    logic              fifo_err_q  [FIFO_DEPTH];
    logic              fifo_wren_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_d, wr_ptr_q, rd_ptr_d, rd_ptr_q;
    logic [CNT_W-1:0]  count_d, count_q, out_d, out_q;
    logic              push_s, pop_s, rsp_valid_s;

    assign accept_s    = bus.req_valid && bus.req_ready;
    assign push_s      = s2_valid_q;
    assign rsp_valid_s = (count_q != {CNT_W{1'b0}});
    assign pop_s       = rsp_valid_s && bus.rsp_ready;

    // Decode bank/offset, range check and per-bank lane write/read strobes
    always_comb begin
        bank_s     = bus.req_address[ADDR_WIDTH-1:BANK_ADDR_WIDTH];
        offset_s   = bus.req_address[BANK_ADDR_WIDTH-1:0];
        in_range_s = (int'(bank_s) < NUM_BANKS) && (int'(offset_s) < BANK_DEPTH);
        narrow_s   = 1'b0;
        bank_we_s  = {(NUM_BANKS * LANES){1'b0}};
        bank_re_s  = {NUM_BANKS{1'b0}};
        for (int b = 0; b < NUM_BANKS; b++) begin
            narrow_s     = (int'(bank_s) == b) ? NARROW_MASK[b] : narrow_s;
            bank_re_s[b] = accept_s && !bus.req_wren && in_range_s && (int'(bank_s) == b);
            for (int l = 0; l < LANES; l++) begin
                bank_we_s[b][l] = accept_s && bus.req_wren && in_range_s && (int'(bank_s) == b)
                                  && bus.req_be[l] && ((l == 0) || !NARROW_MASK[b]);
            end
        end
    end

    // Storage: wide banks get every lane, narrow banks only lane 0
    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        for (genvar l = 0; l < LANES; l++) begin : g_lane
            if ((l == 0) || (NARROW_MASK[b] == 1'b0)) begin : g_ram
                logic [LANE_WIDTH-1:0] mem_q [BANK_DEPTH];
                logic [LANE_WIDTH-1:0] rd_q;
                // Write commits at the acceptance edge; read data is registered (stage 1)
                always_ff @(posedge clock) begin
                    if (bank_we_s[b][l]) begin
                        mem_q[offset_s] <= bus.req_data[l*LANE_WIDTH +: LANE_WIDTH];
                    end
                    if (bank_re_s[b]) begin
                        rd_q <= mem_q[offset_s];
                    end
                end
                assign bank_rd_s[b][l] = rd_q;
            end else begin : g_none
                assign bank_rd_s[b][l] = {LANE_WIDTH{1'b0}};
            end
        end
    end

    // Select the bank addressed in stage 1 and replicate lane 0 for narrow banks
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            lane_rd_s[l] = {LANE_WIDTH{1'b0}};
            for (int b = 0; b < NUM_BANKS; b++) begin
                lane_rd_s[l] = (int'(s1_bank_q) == b) ? bank_rd_s[b][l] : lane_rd_s[l];
            end
        end
        rd_word_s = {W{1'b0}};
        for (int l = 0; l < LANES; l++) begin
            rd_word_s[l*LANE_WIDTH +: LANE_WIDTH] = s1_narrow_q ? lane_rd_s[0] : lane_rd_s[l];
        end
    end

    // Next state of pipeline stages, FIFO pointers/count and credit counter
    always_comb begin
        s1_valid_d  = accept_s;
        s1_wren_d   = bus.req_wren;
        s1_err_d    = !in_range_s;
        s1_narrow_d = narrow_s;
        s1_bank_d   = bank_s;
        s2_valid_d  = s1_valid_q;
        s2_wren_d   = s1_wren_q;
        s2_err_d    = s1_err_q;
        s2_data_d   = (s1_valid_q && !s1_err_q && !s1_wren_q) ? rd_word_s : {W{1'b0}};
        wr_ptr_d    = push_s ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d    = pop_s ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1'b1);
            2'b01:   count_d = count_q - CNT_W'(1'b1);
            default: count_d = count_q;
        endcase
        case ({accept_s, pop_s})
            2'b10:   out_d = out_q + CNT_W'(1'b1);
            2'b01:   out_d = out_q - CNT_W'(1'b1);
            default: out_d = out_q;
        endcase
    end

    // Control and pipeline registers; in-flight work is dropped on reset
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q  <= 1'b0;
            s1_wren_q   <= 1'b0;
            s1_err_q    <= 1'b0;
            s1_narrow_q <= 1'b0;
            s1_bank_q   <= {BANK_W{1'b0}};
            s2_valid_q  <= 1'b0;
            s2_wren_q   <= 1'b0;
            s2_err_q    <= 1'b0;
            s2_data_q   <= {W{1'b0}};
            wr_ptr_q    <= {PTR_W{1'b0}};
            rd_ptr_q    <= {PTR_W{1'b0}};
            count_q     <= {CNT_W{1'b0}};
            out_q       <= {CNT_W{1'b0}};
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_wren_q   <= s1_wren_d;
            s1_err_q    <= s1_err_d;
            s1_narrow_q <= s1_narrow_d;
            s1_bank_q   <= s1_bank_d;
            s2_valid_q  <= s2_valid_d;
            s2_wren_q   <= s2_wren_d;
            s2_err_q    <= s2_err_d;
            s2_data_q   <= s2_data_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_q       <= out_d;
        end
    end

    // FIFO payload storage; validity is tracked by count_q, so no reset needed
    always_ff @(posedge clock) begin
        if (push_s) begin
            fifo_data_q[wr_ptr_q] <= s2_data_q;
            fifo_err_q[wr_ptr_q]  <= s2_err_q;
            fifo_wren_q[wr_ptr_q] <= s2_wren_q;
        end
    end

    assign bus.req_ready = reset_n && (out_q < CNT_W'(FIFO_DEPTH));
    assign bus.rsp_valid = rsp_valid_s;
    assign bus.rsp_data  = rsp_valid_s ? fifo_data_q[rd_ptr_q] : {W{1'b0}};
    assign bus.rsp_error = rsp_valid_s ? fifo_err_q[rd_ptr_q] : 1'b0;
    assign bus.rsp_wren  = rsp_valid_s ? fifo_wren_q[rd_ptr_q] : 1'b0;
endmodule

// File: tb/tb_banked_memory_ctrl.sv
// Directed and table-driven bench for banked_memory_ctrl.
module tb_banked_memory_ctrl;
    typedef struct {
        logic        wren;
        logic [3:0]  be;
        logic [15:0] addr;
        logic [31:0] data;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic        err;
        logic        wren;
        int          acc_cyc;
        bit          chk_lat;
    } exp_t;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    banked_memory_ctrl_if #(.LANE_WIDTH(8), .LANES(4), .ADDR_WIDTH(16)) bus ();

    banked_memory_ctrl #(
        .LANE_WIDTH(8), .LANES(4), .ADDR_WIDTH(16), .BANK_ADDR_WIDTH(12),
        .NUM_BANKS(3), .BANK_DEPTH(3072), .NARROW_MASK(3'b010), .FIFO_DEPTH(4)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          outst = 0;
    int          last_acc_cyc = 0;
    bit          accepted = 1'b0;
    bit          chk_lat_mode = 1'b1;
    string       cur_name = "none";
    exp_t        cur_exp;
    exp_t        expq[$];
    logic [31:0] mdl[int];
    vec_t        vecs[20];
    vec_t        bp[6];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic drive(input logic wren, input logic [3:0] be, input logic [15:0] addr, input logic [31:0] data);
        bus.req_wren    = wren;
        bus.req_be      = be;
        bus.req_address = addr;
        bus.req_data    = data;
    endtask

    // one clock: sample at negedge, score handshakes, return 1 time unit after posedge
    task automatic tick();
        exp_t e;
        @(negedge clock);
        accepted = bus.req_valid && bus.req_ready;
        total++;
        if (bus.req_ready !== (outst < 4)) begin
            bad++;
            $display("FAIL %s ready: got %b want %b (outstanding %0d)", cur_name, bus.req_ready, (outst < 4), outst);
        end
        if (bus.rsp_valid && bus.rsp_ready) begin
            total++;
            if (expq.size() == 0) begin
                bad++;
                $display("FAIL %s stale_rsp: got data=%h err=%b want no response", cur_name, bus.rsp_data, bus.rsp_error);
            end else begin
                e = expq.pop_front();
                outst--;
                if (bus.rsp_data !== e.data || bus.rsp_error !== e.err || bus.rsp_wren !== e.wren) begin
                    bad++;
                    $display("FAIL %s rsp: got data=%h err=%b wren=%b want data=%h err=%b wren=%b",
                             cur_name, bus.rsp_data, bus.rsp_error, bus.rsp_wren, e.data, e.err, e.wren);
                end
                if (e.chk_lat) begin
                    total++;
                    if (cyc - e.acc_cyc != 3) begin
                        bad++;
                        $display("FAIL %s latency: got %0d edges want 2", cur_name, cyc - e.acc_cyc - 1);
                    end
                end
            end
        end
        if (accepted) begin
            e = cur_exp;
            e.acc_cyc = cyc;
            e.chk_lat = chk_lat_mode;
            expq.push_back(e);
            outst++;
            last_acc_cyc = cyc;
        end
        @(posedge clock);
        #1;
        cyc++;
    endtask

    // hold the current request until it is accepted
    task automatic issue(input logic wren, input logic [3:0] be, input logic [15:0] addr, input logic [31:0] data,
                         input logic [31:0] exp_data, input logic exp_err, input bit rand_ready);
        int n;
        drive(wren, be, addr, data);
        cur_exp = '{data: exp_data, err: exp_err, wren: wren, acc_cyc: 0, chk_lat: 1'b0};
        bus.req_valid = 1'b1;
        n = 0;
        do begin
            if (rand_ready) bus.rsp_ready = ($urandom_range(0, 3) != 0);
            tick();
            n++;
        end while (!accepted && n < 50);
        if (!accepted) begin
            total++;
            bad++;
            $display("FAIL %s accept_timeout: got no accept want accept within 50 cycles", cur_name);
        end
    endtask

    task automatic drain(input int limit);
        int n = 0;
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        while (expq.size() != 0 && n < limit) begin
            tick();
            n++;
        end
        check({cur_name, " drain"}, 32'(expq.size()), 32'd0);
    endtask

    function automatic exp_t model_exp(input logic wren, input logic [15:0] a);
        exp_t e;
        e = '{data: 32'h0, err: 1'b0, wren: wren, acc_cyc: 0, chk_lat: 1'b0};
        if (a[15:12] >= 4'd3 || a[11:0] >= 12'd3072) e.err = 1'b1;
        else if (!wren) e.data = (a[15:12] == 4'd1) ? {4{mdl[int'(a)][7:0]}} : mdl[int'(a)];
        return e;
    endfunction

    function automatic void model_write(input logic [3:0] be, input logic [15:0] a, input logic [31:0] d);
        logic [31:0] w;
        if (a[15:12] >= 4'd3 || a[11:0] >= 12'd3072) return;
        w = mdl.exists(int'(a)) ? mdl[int'(a)] : 32'h0;
        if (a[15:12] == 4'd1) begin
            if (be[0]) w[7:0] = d[7:0];
        end else begin
            for (int l = 0; l < 4; l++) if (be[l]) w[l*8 +: 8] = d[l*8 +: 8];
        end
        mdl[int'(a)] = w;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [15:0] pool[9];
        logic [15:0] a;
        logic [31:0] d;
        logic [3:0]  be;
        logic        wr;
        exp_t        e;
        int          p, n, r;
        int          acc_at[6];

        vecs[0]  = '{1'b1, 4'b1111, 16'h0005, 32'hAABBCCDD, 32'h00000000, 1'b0};
        vecs[1]  = '{1'b1, 4'b0101, 16'h0005, 32'h11223344, 32'h00000000, 1'b0};
        vecs[2]  = '{1'b0, 4'b0000, 16'h0005, 32'h00000000, 32'hAA22CC44, 1'b0};
        vecs[3]  = '{1'b1, 4'b0000, 16'h0005, 32'hFFFFFFFF, 32'h00000000, 1'b0};
        vecs[4]  = '{1'b0, 4'b1111, 16'h0005, 32'h00000000, 32'hAA22CC44, 1'b0};
        vecs[5]  = '{1'b1, 4'b0001, 16'h1010, 32'h000000A5, 32'h00000000, 1'b0};
        vecs[6]  = '{1'b0, 4'b0000, 16'h1010, 32'h00000000, 32'hA5A5A5A5, 1'b0};
        vecs[7]  = '{1'b1, 4'b1110, 16'h1010, 32'h777777C3, 32'h00000000, 1'b0};
        vecs[8]  = '{1'b0, 4'b0000, 16'h1010, 32'h00000000, 32'hA5A5A5A5, 1'b0};
        vecs[9]  = '{1'b1, 4'b1111, 16'h0000, 32'h12345678, 32'h00000000, 1'b0};
        vecs[10] = '{1'b1, 4'b1111, 16'h0C00, 32'hCAFEBABE, 32'h00000000, 1'b1};
        vecs[11] = '{1'b0, 4'b0000, 16'h0C00, 32'h00000000, 32'h00000000, 1'b1};
        vecs[12] = '{1'b0, 4'b0000, 16'h3000, 32'h00000000, 32'h00000000, 1'b1};
        vecs[13] = '{1'b1, 4'b1111, 16'h2C00, 32'h55555555, 32'h00000000, 1'b1};
        vecs[14] = '{1'b0, 4'b0000, 16'h0000, 32'h00000000, 32'h12345678, 1'b0};
        vecs[15] = '{1'b1, 4'b1111, 16'h2BFF, 32'hDEADBEEF, 32'h00000000, 1'b0};
        vecs[16] = '{1'b0, 4'b0000, 16'h2BFF, 32'h00000000, 32'hDEADBEEF, 1'b0};
        vecs[17] = '{1'b1, 4'b1111, 16'h1BFF, 32'h0000005A, 32'h00000000, 1'b0};
        vecs[18] = '{1'b0, 4'b0000, 16'h1BFF, 32'h00000000, 32'h5A5A5A5A, 1'b0};
        vecs[19] = '{1'b1, 4'b1111, 16'hF123, 32'h01020304, 32'h00000000, 1'b1};

        bp[0] = '{1'b0, 4'b0000, 16'h0005, 32'h0, 32'hAA22CC44, 1'b0};
        bp[1] = '{1'b0, 4'b0000, 16'h1010, 32'h0, 32'hA5A5A5A5, 1'b0};
        bp[2] = '{1'b0, 4'b0000, 16'h0000, 32'h0, 32'h12345678, 1'b0};
        bp[3] = '{1'b0, 4'b0000, 16'h2BFF, 32'h0, 32'hDEADBEEF, 1'b0};
        bp[4] = '{1'b0, 4'b0000, 16'h3000, 32'h0, 32'h00000000, 1'b1};
        bp[5] = '{1'b0, 4'b0000, 16'h0007, 32'h0, 32'hCAFEF00D, 1'b0};

        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        drive(1'b0, 4'b0000, 16'h0000, 32'h0);

        // reset state
        cur_name = "reset";
        #12;
        check("reset req_ready", {31'b0, bus.req_ready}, 32'd0);
        check("reset rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
        check("reset rsp_data", bus.rsp_data, 32'd0);
        check("reset rsp_error", {31'b0, bus.rsp_error}, 32'd0);
        check("reset rsp_wren", {31'b0, bus.rsp_wren}, 32'd0);
        @(posedge clock);
        #3;
        reset_n = 1'b1;
        #1;
        check("release req_ready", {31'b0, bus.req_ready}, 32'd1);
        @(posedge clock);
        #1;

        // table-driven single transactions with 2-edge latency check
        chk_lat_mode = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cur_name = $sformatf("vec%0d", i);
            issue(vecs[i].wren, vecs[i].be, vecs[i].addr, vecs[i].data, vecs[i].exp_data, vecs[i].exp_err, 1'b0);
            drain(20);
        end

        // read directly after write to the same address, back to back
        cur_name = "hazard";
        issue(1'b1, 4'b1111, 16'h0007, 32'hCAFEF00D, 32'h0, 1'b0, 1'b0);
        issue(1'b0, 4'b0000, 16'h0007, 32'h0, 32'hCAFEF00D, 1'b0, 1'b0);
        issue(1'b1, 4'b0001, 16'h1020, 32'h00000099, 32'h0, 1'b0, 1'b0);
        issue(1'b0, 4'b0000, 16'h1020, 32'h0, 32'h99999999, 1'b0, 1'b0);
        drain(20);

        // backpressure: only 4 accepted while rsp_ready is low
        cur_name = "backpressure";
        chk_lat_mode = 1'b0;
        bus.rsp_ready = 1'b0;
        p = 0;
        for (int c = 0; c < 10; c++) begin
            drive(bp[p].wren, bp[p].be, bp[p].addr, bp[p].data);
            cur_exp = '{data: bp[p].exp_data, err: bp[p].exp_err, wren: 1'b0, acc_cyc: 0, chk_lat: 1'b0};
            bus.req_valid = 1'b1;
            tick();
            if (accepted) begin
                acc_at[p] = last_acc_cyc;
                p++;
            end
        end
        check("bp accepted", 32'(p), 32'd4);
        check("bp req_ready low", {31'b0, bus.req_ready}, 32'd0);
        bus.rsp_ready = 1'b1;
        r = cyc;
        n = 0;
        while (p < 6 && n < 20) begin
            drive(bp[p].wren, bp[p].be, bp[p].addr, bp[p].data);
            cur_exp = '{data: bp[p].exp_data, err: bp[p].exp_err, wren: 1'b0, acc_cyc: 0, chk_lat: 1'b0};
            tick();
            if (accepted) begin
                acc_at[p] = last_acc_cyc;
                p++;
            end
            n++;
        end
        check("bp resume first", 32'(acc_at[4] - r), 32'd1);
        check("bp resume second", 32'(acc_at[5] - r), 32'd2);
        drain(20);

        // reset with 3 responses outstanding
        cur_name = "midreset";
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) issue(bp[i].wren, bp[i].be, bp[i].addr, bp[i].data, bp[i].exp_data, bp[i].exp_err, 1'b0);
        bus.req_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        check("midreset req_ready", {31'b0, bus.req_ready}, 32'd0);
        check("midreset rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
        check("midreset rsp_data", bus.rsp_data, 32'd0);
        check("midreset rsp_error", {31'b0, bus.rsp_error}, 32'd0);
        check("midreset rsp_wren", {31'b0, bus.rsp_wren}, 32'd0);
        expq.delete();
        outst = 0;
        @(posedge clock);
        #3;
        reset_n = 1'b1;
        #1;
        check("midreset release ready", {31'b0, bus.req_ready}, 32'd1);
        @(posedge clock);
        #1;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        chk_lat_mode = 1'b1;
        issue(1'b0, 4'b0000, 16'h0000, 32'h0, 32'h12345678, 1'b0, 1'b0);
        drain(20);

        // streaming with random stalls against a reference model
        cur_name = "stream";
        chk_lat_mode = 1'b0;
        pool = '{16'h0100, 16'h0101, 16'h0102, 16'h1100, 16'h1101, 16'h2100, 16'h2101, 16'h0C10, 16'h3100};
        for (int i = 0; i < 7; i++) begin
            d = $urandom();
            e = model_exp(1'b1, pool[i]);
            issue(1'b1, 4'b1111, pool[i], d, e.data, e.err, 1'b1);
            model_write(4'b1111, pool[i], d);
        end
        for (int i = 0; i < 64; i++) begin
            a  = pool[$urandom_range(0, 8)];
            wr = 1'($urandom_range(0, 1));
            be = 4'($urandom_range(0, 15));
            d  = $urandom();
            e  = model_exp(wr, a);
            issue(wr, be, a, d, e.data, e.err, 1'b1);
            if (wr) model_write(be, a, d);
        end
        drain(40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/banked_memory_ctrl.md
# banked_memory_ctrl

Parametrised successor to the fixed three-region byte-lane data memory used by the matrix-multiplication datapath. It decodes a word address into one of NUM_BANKS banks and stores each bank as LANES independent byte-lane RAMs. Wide banks use every lane with byte enables; narrow banks hold a single byte per word, and a narrow read returns that byte replicated across all lanes. It adds what the fixed version lacks:

- a valid/ready request port;
- a pipelined read path;
- per-access range checking;
- a credit-limited response FIFO with backpressure.

## Interface

Parameters:
- LANE_WIDTH, 8, bits per byte lane
- LANES, 4, lanes per word; word width W = LANES*LANE_WIDTH
- ADDR_WIDTH, 16, request address width
- BANK_ADDR_WIDTH, 12, offset bits; the bank index is address[ADDR_WIDTH-1:BANK_ADDR_WIDTH]
- NUM_BANKS, 3, number of populated banks
- BANK_DEPTH, 3072, valid words per bank; must be ≤ 2^BANK_ADDR_WIDTH
- NARROW_MASK, 3'b010, bit b=1 makes bank b narrow
- FIFO_DEPTH, 4, response FIFO entries and outstanding-request limit; must be ≥ 3

Ports:
- clock  in  1  single clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted this cycle when req_valid is also high
- req_wren  in  1  1 = write, 0 = read
- req_be  in  LANES  write byte enables; ignored for reads
- req_address  in  ADDR_WIDTH  word address
- req_data  in  W  write data
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed this cycle when rsp_valid is also high
- rsp_data  out  W  read data; 0 for writes and for errors
- rsp_error  out  1  address was out of range
- rsp_wren  out  1  echoes req_wren of the request this response belongs to

## Operation

Acceptance and ordering:
- A request is accepted on a rising edge where req_valid && req_ready.
- Every accepted request, read or write, produces exactly one response.
- Responses are returned strictly in acceptance order.

Address decode:
- bank = upper address bits; offset = address[BANK_ADDR_WIDTH-1:0].
- The request is out of range if bank ≥ NUM_BANKS or offset ≥ BANK_DEPTH.
- An out-of-range request never writes storage and returns rsp_error=1 with rsp_data=0.

Wide bank writes:
- Lane l is written with req_data[l*LANE_WIDTH +: LANE_WIDTH] only when req_be[l]=1.
- A write with req_be all zero is legal: nothing is written and a normal response is returned.

Narrow bank writes:
- Only lane 0 storage exists.
- The write stores req_data[LANE_WIDTH-1:0] when req_be[0]=1.
- req_be[LANES-1:1] is ignored.

Reads:
- A wide read returns the concatenated lanes.
- A narrow read returns the stored byte replicated LANES times.

Pipeline:
- Stage 1 registers the decode results and performs the synchronous RAM access. Writes commit at the acceptance edge.
- Stage 2 captures the RAM output, applies replication and error masking, and pushes the response into the FIFO.
- The FIFO drives rsp_* from its head.

Credit counter:
- outstanding counts requests accepted but not yet consumed by a response handshake.
- It is incremented on acceptance and decremented on rsp_valid && rsp_ready.
- Both on the same edge leaves it unchanged.
- req_ready = reset_n && (outstanding < FIFO_DEPTH). This guarantees the FIFO never overflows and the pipeline never stalls.

Memory contents:
- RAM contents are not initialised and are not cleared by reset.
- Reads of never-written locations return X in simulation.

## Timing

Reset (reset_n low, asynchronous):
- Pipeline valids, FIFO pointers and outstanding are cleared immediately.
- req_ready=0, rsp_valid=0, rsp_data=0, rsp_error=0, rsp_wren=0.
- req_ready rises in the first cycle after reset_n is deasserted.

Reset mid-operation:
- All in-flight responses are discarded.
- Writes that were already accepted remain committed.

Latency:
- A request accepted at edge E0 has its response visible (rsp_valid=1) after edge E0+2, provided the FIFO holds no older responses.
- With the FIFO already non-empty, the response follows the older entries in order.

Throughput:
- With rsp_ready held high, one request per cycle is sustained indefinitely.

Backpressure:
- With rsp_ready low, exactly FIFO_DEPTH requests are accepted, then req_ready drops.
- req_ready rises in the cycle after the first response handshake.

Hazards:
- A read accepted the edge after a write to the same address returns the new data.
- Only one request per cycle exists, so there is no same-edge read/write conflict.

FIFO boundaries:
- Simultaneous push and pop while full is not reachable, because the credit counter prevents it.
- Simultaneous push and pop while empty passes through with the 2-cycle latency unchanged.
- Pointers wrap modulo FIFO_DEPTH.

## Test plan

- **Reset.** Assert reset_n=0 mid-burst with 3 responses outstanding. Required: all rsp_* read 0 and req_ready=0 immediately. After release, req_ready=1 and no stale response ever appears.
- **Byte-enable write.** Wide bank 0, address 0x0005: write 0xAABBCCDD with be=4'b1111, then write 0x11223344 with be=4'b0101, then read. Required: response 0xAA22CC44 two cycles after the read is accepted.
- **Narrow bank.** Bank 1, address 0x1010: write 0x000000A5 with be=4'b0001, then read. Required: rsp_data=0xA5A5A5A5, rsp_error=0.
- **Range errors.** Write then read at address 0x0C00 (offset 3072). Then read address 0x3000 (bank 3). Required: rsp_error=1 and rsp_data=0 for each request. Afterwards a legal read of 0x0000 returns its prior contents unchanged.
- **Backpressure.** Hold rsp_ready=0 and issue 6 back-to-back reads. Required: exactly 4 accepted and req_ready=0 thereafter. Then release rsp_ready. Required: 6 in-order responses and 1 accept per cycle resumes.
- **Streaming.** Issue 64 random mixed reads and writes with random rsp_ready stalls. Required: responses match the scoreboard in order and outstanding never exceeds 4.
